obi_wb_arbiter: RTL

Two-port OBI-to-Wishbone arbiter sharing one Wishbone classic master bus between the cv32e40p instruction and data OBI ports when the design has a single memory (no `ENABLE_SECOND_MEMORY`). Sits between `cv32e40p_core` and the `core_*` bus in `processorci_top`. It performs round-robin arbitration, runs one Wishbone transfer at a time, returns the response on the granted port, and terminates hung transfers with an error after a bounded timeout.

---
 rtl/obi_wb_arbiter_if.sv | 51 +++++
 rtl/obi_wb_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/obi_wb_arbiter_if.sv
// Bus bundle for the two-port OBI to Wishbone classic arbiter: instruction and
// data OBI ports on one side, the shared Wishbone master bus on the other.
interface obi_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  instr_req_i;
  logic                  instr_gnt_o;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_rvalid_o;
  logic [31:0]           instr_rdata_o;
  logic                  instr_err_o;

  logic                  data_req_i;
  logic                  data_gnt_o;
  logic                  data_we_i;
  logic [3:0]            data_be_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic [31:0]           data_wdata_i;
  logic                  data_rvalid_o;
  logic [31:0]           data_rdata_o;
  logic                  data_err_o;

  logic                  core_cyc;
  logic                  core_stb;
  logic                  core_we;
  logic [3:0]            core_wstrb;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [31:0]           core_data_out;
  logic [31:0]           core_data_in;
  logic                  core_ack;

  // arbiter side
  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  core_data_in, core_ack,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out
  );

  // core + memory side
  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output core_data_in, core_ack,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  core_cyc, core_stb, core_we, core_wstrb, core_addr, core_data_out
  );
endinterface

// File: rtl/obi_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic master between the
// cv32e40p instruction and data OBI ports, with a bounded-timeout error path.
//
// state | meaning
// IDLE  | arbitrate, grant combinationally, latch the winning request
// BUS   | Wishbone cycle active, wait for ack or timeout
// RESP  | one-cycle rvalid pulse on the owning port
module obi_wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  obi_wb_arbiter_if.slave bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_data_q;
  logic                  last_grant_data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic [31:0]           instr_rdata_q;
  logic [31:0]           data_rdata_q;
  logic                  err_q;
  logic [CW-1:0]         cnt_q;

  logic instr_win, data_win, timeout_hit;

  // Tie goes to the port that was not granted last.
  always_comb begin
    instr_win   = bus.instr_req_i & (~bus.data_req_i | last_grant_data_q);
    data_win    = bus.data_req_i & (~bus.instr_req_i | ~last_grant_data_q);
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_TC);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_win | data_win) state_d = BUS;
      BUS:     if (bus.core_ack | timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants are gated by rst_n so they stay low while reset is asserted.
  always_comb begin
    bus.instr_gnt_o    = instr_win & (state_q == IDLE) & rst_n;
    bus.data_gnt_o     = data_win & (state_q == IDLE) & rst_n;
    bus.core_cyc       = (state_q == BUS);
    bus.core_stb       = (state_q == BUS);
    bus.instr_rvalid_o = (state_q == RESP) & ~owner_data_q;
    bus.data_rvalid_o  = (state_q == RESP) & owner_data_q;
    bus.instr_err_o    = bus.instr_rvalid_o & err_q;
    bus.data_err_o     = bus.data_rvalid_o & err_q;
  end

  assign bus.core_we       = we_q;
  assign bus.core_wstrb    = sel_q;
  assign bus.core_addr     = addr_q;
  assign bus.core_data_out = wdata_q;
  assign bus.instr_rdata_o = instr_rdata_q;
  assign bus.data_rdata_o  = data_rdata_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_data_q      <= 1'b0;
      last_grant_data_q <= 1'b1;
      addr_q            <= '0;
      we_q              <= 1'b0;
      sel_q             <= 4'h0;
      wdata_q           <= 32'h0;
      instr_rdata_q     <= 32'h0;
      data_rdata_q      <= 32'h0;
      err_q             <= 1'b0;
      cnt_q             <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_win | data_win) begin
            owner_data_q      <= ~instr_win;
            last_grant_data_q <= ~instr_win;
            addr_q            <= instr_win ? bus.instr_addr_i : bus.data_addr_i;
            we_q              <= instr_win ? 1'b0 : bus.data_we_i;
            sel_q             <= instr_win ? 4'hF : bus.data_be_i;
            wdata_q           <= instr_win ? 32'h0 : bus.data_wdata_i;
            cnt_q             <= '0;
          end
        end
        BUS: begin
          // ack wins over a same-cycle timeout
          if (bus.core_ack) begin
            if (owner_data_q) data_rdata_q  <= bus.core_data_in;
            else              instr_rdata_q <= bus.core_data_in;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            if (owner_data_q) data_rdata_q  <= 32'h0;
            else              instr_rdata_q <= 32'h0;
            err_q <= 1'b1;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
